// File: rtl/regfile_mp.sv
// Multi-port register file with write-priority resolution, busy scoreboard and conflict counter.
// Define REGFILE_BYPASS_EN to compile in same-cycle write-to-read forwarding.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_idx,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_idx,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_idx,
  output logic [NREGS-1:0]    busy_vec,
  output logic                err_wr_conflict,
  output logic [7:0]          err_count
);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             err_q, err_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [AW-1:0]    rd_idx_a [NRD];
  logic [AW-1:0]    wr_idx_a [NWR];
  logic [NREGS-1:0] wr_hit;
  logic [XLEN-1:0]  wr_win [NREGS];

  for (genvar gp = 0; gp < NRD; gp++) begin : g_rd_idx
    assign rd_idx_a[gp] = rd_idx[gp*AW +: AW];
  end
  for (genvar gp = 0; gp < NWR; gp++) begin : g_wr_idx
    assign wr_idx_a[gp] = wr_idx[gp*AW +: AW];
  end

  // Ascending port scan: a later port overwrites an earlier one, so the highest port wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    wr_hit = '0;
    err_d  = 1'b0;
    for (int r = 0; r < NREGS; r++) wr_win[r] = '0;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && !(ZERO_REG != 0 && wr_idx_a[p] == '0)) begin
        if (wr_hit[wr_idx_a[p]]) err_d = 1'b1;
        wr_hit[wr_idx_a[p]] = 1'b1;
        wr_win[wr_idx_a[p]] = wr_data[p*XLEN +: XLEN];
      end
    end
  end

  // Clear on writeback first, then set on issue so a new producer supersedes the old one.
  always_comb begin
    busy_d = busy_q & ~wr_hit;
    if (iss_en && !(ZERO_REG != 0 && iss_idx == '0)) busy_d[iss_idx] = 1'b1;
    cnt_d = cnt_q;
    if (err_d && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the storage array is in the reset domain on purpose; all entries must read 0 straight after reset.
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      for (int r = 0; r < NREGS; r++) begin
        if (wr_hit[r]) mem_q[r] <= wr_win[r];
      end
      busy_q <= busy_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_data[p*XLEN +: XLEN] = mem_q[rd_idx_a[p]];
      rd_busy[p]              = busy_q[rd_idx_a[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit[rd_idx_a[p]]) begin
        rd_data[p*XLEN +: XLEN] = wr_win[rd_idx_a[p]];
        rd_busy[p]              = busy_d[rd_idx_a[p]];
      end
`endif
      if (ZERO_REG != 0 && rd_idx_a[p] == '0) begin
        rd_data[p*XLEN +: XLEN] = '0;
        rd_busy[p]              = 1'b0;
      end
    end
  end

  assign busy_vec        = busy_q;
  assign err_wr_conflict = err_q;
  assign err_count       = cnt_q;

endmodule
